// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the fetch front end: address/instruction
// types, opcode fields, FSM encodings and the instruction queue entry layout.
package instruction_fetcher_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam logic [6:0] OPCODE_JAL = 7'b1101111;
    localparam logic [6:0] OPCODE_BR  = 7'b1100011;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    typedef struct packed {
        inst_t inst;
        addr_t pc;
        logic  pred_taken;
    } iq_entry_t;

    function automatic logic [6:0] opcode_of(input inst_t inst);
        return inst[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bus bundle between the fetcher and its neighbours: memory/icache port,
// branch predictor port, instruction queue head and ROB rollback.
interface instruction_fetcher_if;
    import instruction_fetcher_pkg::*;

    logic  mem_req_flag;
    addr_t mem_req_addr;
    logic  mem_done_flag;
    inst_t mem_inst;

    addr_t bp_pc;
    inst_t bp_inst;
    logic  bp_jump_flag;
    addr_t bp_imm;

    logic  iq_valid;
    inst_t iq_inst;
    addr_t iq_pc;
    logic  iq_pred_taken;
    logic  iq_pop;

    logic  rollback_flag;
    addr_t rollback_pc;

    modport master (
        output mem_req_flag, mem_req_addr,
        input  mem_done_flag, mem_inst,
        output bp_pc, bp_inst,
        input  bp_jump_flag, bp_imm,
        output iq_valid, iq_inst, iq_pc, iq_pred_taken,
        input  iq_pop,
        input  rollback_flag, rollback_pc
    );

    modport slave (
        input  mem_req_flag, mem_req_addr,
        output mem_done_flag, mem_inst,
        input  bp_pc, bp_inst,
        output bp_jump_flag, bp_imm,
        input  iq_valid, iq_inst, iq_pc, iq_pred_taken,
        output iq_pop,
        output rollback_flag, rollback_pc
    );

endinterface

// File: rtl/instruction_fetcher_inst_queue.sv
// Circular FIFO of fetched instructions with synchronous flush; the head
// entry reads as all-zero while the queue is empty.
module inst_queue
    import instruction_fetcher_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  iq_entry_t                push_data,
    input  logic                     pop,
    output iq_entry_t                head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             pop_en;
    logic             push_en;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_en) tail <= tail + 1'b1;
            if (pop_en)  head <= head + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !flush) mem[tail] <= push_data;
    end

    assign head_data = empty ? '0 : mem[head];

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the PC, issues one fetch at a time, steers the PC with
// the branch prediction and buffers results in the instruction queue.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    instruction_fetcher_if.master bus
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    logic [1:0]       state;
    addr_t            pc;
    addr_t            pc_next;
    logic             req;
    logic             q_push;
    logic             q_pop;
    logic             q_flush;
    logic             q_empty;
    logic             q_full;
    logic [CNT_W-1:0] q_count;
    iq_entry_t        q_in;
    iq_entry_t        q_head;

    assign req = rst & rdy & ~bus.rollback_flag & (state == ST_IDLE)
               & (q_count < CNT_W'(IQ_DEPTH));

    assign pc_next = bus.bp_jump_flag ? pc + bus.bp_imm : pc + 32'd4;

    assign q_flush = rdy & bus.rollback_flag;
    assign q_pop   = rdy & ~bus.rollback_flag & bus.iq_pop;
    assign q_push  = rdy & ~bus.rollback_flag & (state == ST_WAIT)
                   & bus.mem_done_flag & (~q_full | q_pop);
    assign q_in    = '{inst: bus.mem_inst, pc: pc, pred_taken: bus.bp_jump_flag};

    // Rollback outranks everything; an in-flight fetch must still be drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else if (rdy) begin
            if (bus.rollback_flag) begin
                pc <= bus.rollback_pc;
                case (state)
                    ST_WAIT, ST_DISCARD: state <= bus.mem_done_flag ? ST_IDLE : ST_DISCARD;
                    default:             state <= ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req) state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (bus.mem_done_flag) begin
                            pc    <= pc_next;
                            state <= ST_IDLE;
                        end
                    end
                    ST_DISCARD: begin
                        if (bus.mem_done_flag) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    inst_queue #(.DEPTH(IQ_DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .head_data (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    assign bus.mem_req_flag  = req;
    assign bus.mem_req_addr  = pc;
    assign bus.bp_pc         = pc;
    assign bus.bp_inst       = bus.mem_inst;
    assign bus.iq_valid      = ~q_empty;
    assign bus.iq_inst       = q_head.inst;
    assign bus.iq_pc         = q_head.pc;
    assign bus.iq_pred_taken = q_head.pred_taken;

endmodule
